fir_serial_mac: RTL and testbench

- Next-generation FIR filter for the analogue front-end path: order, channel count and widths are parametrised.
- Uses one time-multiplexed multiply-accumulate (MAC) unit instead of N+1 parallel multipliers.
- Adds a valid/ready input handshake, interleaved multi-channel operation, and run-time coefficient loading through a shadow bank.
- Output is rounded and saturated. Sits between the ADC capture stage and the decimator/trigger logic.

---
 rtl/fir_serial_mac_pkg.sv | 25 ++
 rtl/fir_round_sat.sv | 45 ++++
 rtl/fir_serial_mac.sv | 219 +++++++++++++++++++++
 tb/tb_fir_serial_mac.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_serial_mac_pkg.sv
// Shared definitions for the serial-MAC FIR filter.
//   state_t  : controller states (IDLE accepts, MAC accumulates, OUT presents)
//   clog2    : ceil(log2(v)), 0 for v <= 1
//   idx_w    : index width for a table of v entries, never less than 1
package fir_serial_mac_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int idx_w(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up and saturation of the MAC accumulator.
//   acc : signed accumulator, Q fractional bits
//   y   : round(acc / 2^Q) clamped to the signed Y_WIDTH range
//   sat : high when the clamp was applied
module fir_round_sat #(
    parameter int ACC_WIDTH = 31,
    parameter int Y_WIDTH   = 16,
    parameter int Q         = 14
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    output logic signed [Y_WIDTH-1:0]   y,
    output logic                        sat
);

    // One guard bit keeps the +half from wrapping at the accumulator extremes.
    localparam int R_W = ACC_WIDTH + 1 - Q;

    localparam logic signed [ACC_WIDTH:0] HALF =
        {{(ACC_WIDTH + 1 - Q){1'b0}}, 1'b1, {(Q - 1){1'b0}}};
    localparam logic signed [R_W-1:0] R_MAX =
        {{(R_W - Y_WIDTH + 1){1'b0}}, {(Y_WIDTH - 1){1'b1}}};
    localparam logic signed [R_W-1:0] R_MIN = ~R_MAX;

    function automatic logic signed [R_W-1:0] round_half_up(
        input logic signed [ACC_WIDTH-1:0] a
    );
        logic signed [ACC_WIDTH:0] s;
        s = $signed({a[ACC_WIDTH-1], a}) + HALF;
        return R_W'(s >>> Q);
    endfunction

    // Returns {sat, y}.
    function automatic logic [Y_WIDTH:0] saturate(input logic signed [R_W-1:0] r);
        if (r > R_MAX) begin
            return {1'b1, R_MAX[Y_WIDTH-1:0]};
        end else if (r < R_MIN) begin
            return {1'b1, R_MIN[Y_WIDTH-1:0]};
        end else begin
            return {1'b0, r[Y_WIDTH-1:0]};
        end
    endfunction

    assign {sat, y} = saturate(round_half_up(acc));

endmodule

// File: rtl/fir_serial_mac.sv
// Order-N FIR filter built around one time-multiplexed multiply-accumulate.
// Samples for CHANNELS interleaved channels arrive over a valid/ready
// handshake; each channel keeps its own delay line. Coefficients are written
// into a shadow bank and copied to the active bank on commit, never while a
// computation is in flight.
//   clk, rst          : clock, synchronous active-high reset
//   x_valid/x_ready   : input handshake; x_chan selects the channel, x the sample
//   coeff_we/addr/data: shadow-bank write (addresses above N are ignored)
//   coeff_commit      : copy shadow to active bank (deferred while busy)
//   y_valid           : one-cycle pulse with y, y_chan, y_sat (registered, held)
module fir_serial_mac
    import fir_serial_mac_pkg::*;
#(
    parameter int N           = 4,
    parameter int CHANNELS    = 1,
    parameter int X_WIDTH     = 12,
    parameter int Y_WIDTH     = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int Q           = 14,
    parameter int ACC_WIDTH   = X_WIDTH + COEFF_WIDTH + clog2(N + 1),
    parameter int CH_W        = idx_w(CHANNELS),
    parameter int TAP_W       = idx_w(N + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          x_valid,
    output logic                          x_ready,
    input  logic [CH_W-1:0]               x_chan,
    input  logic signed [X_WIDTH-1:0]     x,
    input  logic                          coeff_we,
    input  logic [TAP_W-1:0]              coeff_addr,
    input  logic signed [COEFF_WIDTH-1:0] coeff_data,
    input  logic                          coeff_commit,
    output logic                          y_valid,
    output logic [CH_W-1:0]               y_chan,
    output logic signed [Y_WIDTH-1:0]     y,
    output logic                          y_sat
);

    localparam int PROD_W = X_WIDTH + COEFF_WIDTH;

    state_t                        state_q, state_d;
    logic [CH_W-1:0]               chan_q, chan_d;
    logic [TAP_W-1:0]              tap_q, tap_d;
    logic                          drain_q, drain_d;
    logic                          prod_vld_q, prod_vld_d;
    logic signed [PROD_W-1:0]      prod_q, prod_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                          commit_pend_q, commit_pend_d;
    logic                          x_ready_q, x_ready_d;
    logic                          y_valid_q, y_valid_d;
    logic [CH_W-1:0]               y_chan_q, y_chan_d;
    logic signed [Y_WIDTH-1:0]     y_q, y_d;
    logic                          y_sat_q, y_sat_d;

    logic signed [X_WIDTH-1:0]     z_q [CHANNELS][N+1];
    logic signed [X_WIDTH-1:0]     z_d [CHANNELS][N+1];
    logic signed [COEFF_WIDTH-1:0] h_sh_q  [N+1];
    logic signed [COEFF_WIDTH-1:0] h_sh_d  [N+1];
    logic signed [COEFF_WIDTH-1:0] h_act_q [N+1];
    logic signed [COEFF_WIDTH-1:0] h_act_d [N+1];

    logic signed [ACC_WIDTH-1:0]   acc_sum;
    logic signed [Y_WIDTH-1:0]     rs_y;
    logic                          rs_sat;
    logic                          chan_ok;
    logic                          addr_ok;

    // The product is registered, so the accumulator trails the tap counter by
    // one cycle; the final drain cycle adds the last product and feeds the
    // rounder directly so the result lands in the output registers on OUT entry.
    assign acc_sum = acc_q + ACC_WIDTH'(prod_q);
    assign chan_ok = int'({1'b0, x_chan}) < CHANNELS;
    assign addr_ok = int'({1'b0, coeff_addr}) <= N;

    fir_round_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .Y_WIDTH   (Y_WIDTH),
        .Q         (Q)
    ) u_round_sat (
        .acc (acc_sum),
        .y   (rs_y),
        .sat (rs_sat)
    );

    always_comb begin
        state_d       = state_q;
        chan_d        = chan_q;
        tap_d         = tap_q;
        drain_d       = drain_q;
        prod_vld_d    = 1'b0;
        prod_d        = prod_q;
        acc_d         = acc_q;
        commit_pend_d = commit_pend_q;
        y_chan_d      = y_chan_q;
        y_d           = y_q;
        y_sat_d       = y_sat_q;
        z_d           = z_q;
        h_sh_d        = h_sh_q;
        h_act_d       = h_act_q;

        // Shadow writes are legal in every state; a commit in the same cycle
        // copies from h_sh_d so it already contains this write.
        if (coeff_we && addr_ok) begin
            h_sh_d[coeff_addr] = coeff_data;
        end

        case (state_q)
            S_IDLE: begin
                if (coeff_commit) begin
                    h_act_d = h_sh_d;
                end
                // Out-of-range channels are accepted but dropped.
                if (x_valid && x_ready_q && chan_ok) begin
                    for (int k = N; k > 0; k--) begin
                        z_d[x_chan][k] = z_q[x_chan][k-1];
                    end
                    z_d[x_chan][0] = x;
                    chan_d  = x_chan;
                    acc_d   = '0;
                    tap_d   = '0;
                    drain_d = 1'b0;
                    state_d = S_MAC;
                end
            end

            S_MAC: begin
                if (coeff_commit) begin
                    commit_pend_d = 1'b1;
                end
                if (!drain_q) begin
                    prod_d     = PROD_W'(z_q[chan_q][tap_q]) * PROD_W'(h_act_q[tap_q]);
                    prod_vld_d = 1'b1;
                    if (tap_q == TAP_W'(N)) begin
                        drain_d = 1'b1;
                    end else begin
                        tap_d = tap_q + TAP_W'(1);
                    end
                end
                if (prod_vld_q) begin
                    acc_d = acc_sum;
                end
                if (drain_q) begin
                    y_d      = rs_y;
                    y_sat_d  = rs_sat;
                    y_chan_d = chan_q;
                    state_d  = S_OUT;
                end
            end

            S_OUT: begin
                // Deferred commit lands on the edge back into IDLE.
                if (commit_pend_q || coeff_commit) begin
                    h_act_d       = h_sh_d;
                    commit_pend_d = 1'b0;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        x_ready_d = (state_d == S_IDLE);
        y_valid_d = (state_d == S_OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            chan_q        <= '0;
            tap_q         <= '0;
            drain_q       <= 1'b0;
            prod_vld_q    <= 1'b0;
            prod_q        <= '0;
            acc_q         <= '0;
            commit_pend_q <= 1'b0;
            x_ready_q     <= 1'b0;
            y_valid_q     <= 1'b0;
            y_chan_q      <= '0;
            y_q           <= '0;
            y_sat_q       <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k <= N; k++) begin
                    z_q[c][k] <= '0;
                end
            end
            for (int k = 0; k <= N; k++) begin
                h_sh_q[k]  <= '0;
                h_act_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            chan_q        <= chan_d;
            tap_q         <= tap_d;
            drain_q       <= drain_d;
            prod_vld_q    <= prod_vld_d;
            prod_q        <= prod_d;
            acc_q         <= acc_d;
            commit_pend_q <= commit_pend_d;
            x_ready_q     <= x_ready_d;
            y_valid_q     <= y_valid_d;
            y_chan_q      <= y_chan_d;
            y_q           <= y_d;
            y_sat_q       <= y_sat_d;
            z_q           <= z_d;
            h_sh_q        <= h_sh_d;
            h_act_q       <= h_act_d;
        end
    end

    assign x_ready = x_ready_q;
    assign y_valid = y_valid_q;
    assign y_chan  = y_chan_q;
    assign y       = y_q;
    assign y_sat   = y_sat_q;

endmodule

// File: tb/tb_fir_serial_mac.sv
// Randomised and directed bench for fir_serial_mac against a behavioural
// sum-of-products model.
module tb_fir_serial_mac;

    localparam int N           = 4;
    localparam int CHANNELS    = 3;
    localparam int X_WIDTH     = 12;
    localparam int Y_WIDTH     = 12;
    localparam int COEFF_WIDTH = 16;
    localparam int Q           = 14;
    localparam int CH_W        = 2;
    localparam int TAP_W       = 3;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          x_valid;
    logic                          x_ready;
    logic [CH_W-1:0]               x_chan;
    logic signed [X_WIDTH-1:0]     x;
    logic                          coeff_we;
    logic [TAP_W-1:0]              coeff_addr;
    logic signed [COEFF_WIDTH-1:0] coeff_data;
    logic                          coeff_commit;
    logic                          y_valid;
    logic [CH_W-1:0]               y_chan;
    logic signed [Y_WIDTH-1:0]     y;
    logic                          y_sat;

    fir_serial_mac #(
        .N           (N),
        .CHANNELS    (CHANNELS),
        .X_WIDTH     (X_WIDTH),
        .Y_WIDTH     (Y_WIDTH),
        .COEFF_WIDTH (COEFF_WIDTH),
        .Q           (Q)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .x_valid      (x_valid),
        .x_ready      (x_ready),
        .x_chan       (x_chan),
        .x            (x),
        .coeff_we     (coeff_we),
        .coeff_addr   (coeff_addr),
        .coeff_data   (coeff_data),
        .coeff_commit (coeff_commit),
        .y_valid      (y_valid),
        .y_chan       (y_chan),
        .y            (y),
        .y_sat        (y_sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;
    int t_acc  = 0;

    // Reference state: per-channel history, shadow/active coefficient sets.
    int hist [CHANNELS][N+1];
    int h_sh  [N+1];
    int h_act [N+1];
    bit pend;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic void model_reset();
        for (int c = 0; c < CHANNELS; c++)
            for (int k = 0; k <= N; k++) hist[c][k] = 0;
        for (int k = 0; k <= N; k++) begin
            h_sh[k]  = 0;
            h_act[k] = 0;
        end
        pend = 0;
    endfunction

    function automatic void model_push(input int ch, input int xv);
        for (int k = N; k > 0; k--) hist[ch][k] = hist[ch][k-1];
        hist[ch][0] = xv;
    endfunction

    function automatic void model_out(input int ch, output int ye, output int se);
        longint acc = 0;
        longint r;
        longint ymax = (longint'(1) << (Y_WIDTH - 1)) - 1;
        longint ymin = -(longint'(1) << (Y_WIDTH - 1));
        for (int k = 0; k <= N; k++) acc += longint'(hist[ch][k]) * longint'(h_act[k]);
        r = (acc + (longint'(1) << (Q - 1))) >>> Q;
        se = 0;
        if (r > ymax) begin r = ymax; se = 1; end
        if (r < ymin) begin r = ymin; se = 1; end
        ye = int'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; x_valid = 1'b0; coeff_we = 1'b0; coeff_commit = 1'b0;
        repeat (3) tick();
        chk("rst_x_ready", x_ready, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_y_chan", y_chan, 0);
        chk("rst_y_sat", y_sat, 0);
        rst = 1'b0;
        model_reset();
        tick();
        chk("rst_x_ready_after", x_ready, 1);
    endtask

    // Only called while the DUT is idle.
    task automatic wr_coef(input int addr, input int val, input bit commit);
        coeff_we = 1'b1; coeff_addr = TAP_W'(addr); coeff_data = COEFF_WIDTH'(val);
        coeff_commit = commit;
        tick();
        coeff_we = 1'b0; coeff_commit = 1'b0;
        if (addr <= N) h_sh[addr] = val;
        if (commit) h_act = h_sh;
    endtask

    task automatic load_taps(input int v0, input int v1, input int v2, input int v3, input int v4);
        wr_coef(0, v0, 0);
        wr_coef(1, v1, 0);
        wr_coef(2, v2, 0);
        wr_coef(3, v3, 0);
        wr_coef(4, v4, 1);
    endtask

    task automatic accept(input int ch, input int xv, input bit with_commit);
        int n = 0;
        while (!x_ready && n < 64) begin tick(); n++; end
        chk("x_ready_wait", x_ready, 1);
        x_valid = 1'b1; x_chan = CH_W'(ch); x = X_WIDTH'(xv); coeff_commit = with_commit;
        t_acc = cyc;
        tick();
        x_valid = 1'b0; coeff_commit = 1'b0;
        if (with_commit) h_act = h_sh;
        if (ch < CHANNELS) model_push(ch, xv);
    endtask

    // Commit (optionally with a shadow write) two cycles into MAC.
    task automatic mid_commit(input int addr, input int val, input bit we);
        tick();
        coeff_we = we; coeff_addr = TAP_W'(addr); coeff_data = COEFF_WIDTH'(val);
        coeff_commit = 1'b1;
        tick();
        coeff_we = 1'b0; coeff_commit = 1'b0;
        if (we && addr <= N) h_sh[addr] = val;
        pend = 1;
    endtask

    task automatic collect(input string tag, input int ch);
        int ye, se;
        int n = 0;
        model_out(ch, ye, se);
        while (!y_valid && n < 32) begin tick(); n++; end
        chk({tag, "_lat"}, cyc - t_acc, N + 3);
        chk({tag, "_y"}, y, ye);
        chk({tag, "_chan"}, y_chan, ch);
        chk({tag, "_sat"}, y_sat, se);
        tick();
        chk({tag, "_pulse"}, y_valid, 0);
        if (pend) begin h_act = h_sh; pend = 0; end
    endtask

    task automatic no_output(input string tag);
        int hits = 0;
        chk({tag, "_still_ready"}, x_ready, 1);
        repeat (N + 4) begin
            if (y_valid) hits++;
            tick();
        end
        chk({tag, "_no_y"}, hits, 0);
    endtask

    task automatic run(input string tag, input int ch, input int xv);
        accept(ch, xv, 0);
        if (ch < CHANNELS) collect(tag, ch);
        else no_output(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cyc[$];
        int yv;
        int hits;
        rst = 1'b1; x_valid = 1'b0; x_chan = '0; x = '0;
        coeff_we = 1'b0; coeff_addr = '0; coeff_data = '0; coeff_commit = 1'b0;
        do_reset();

        // Impulse through an all-4096 filter.
        load_taps(4096, 4096, 4096, 4096, 4096);
        run("imp", 0, 1000);
        for (int i = 0; i < 5; i++) run("imp", 0, 0);

        // Rounding around the half-LSB point.
        load_taps(8, 0, 0, 0, 0);
        run("rnd_half", 0, 1024);
        run("rnd_neg_half", 0, -1024);
        run("rnd_below", 0, 1023);
        load_taps(16, 0, 0, 0, 0);
        run("rnd_neg_1p5", 0, -1536);

        // Saturation both ways.
        load_taps(16383, 16383, 16383, 16383, 16383);
        for (int i = 0; i < 5; i++) run("sat_pos", 0, 2047);
        for (int i = 0; i < 5; i++) run("sat_neg", 0, -2048);

        // Interleaved channels, then the previous-sample tap only.
        load_taps(16384, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            run("mc_h0", 0, 100);
            run("mc_h0", 1, -200);
        end
        load_taps(0, 16384, 0, 0, 0);
        run("mc_h1", 0, 7);
        run("mc_h1", 1, 9);
        run("mc_h1", 0, 11);
        run("mc_bad_chan", 3, 500);
        run("mc_h1", 1, 13);

        // Commit during MAC, out-of-range address, commit with accept.
        load_taps(4096, 4096, 4096, 4096, 4096);
        run("cm_pre", 0, 1000);
        run("cm_pre", 0, 1000);
        for (int k = 0; k <= N; k++) wr_coef(k, 8192, 0);
        accept(0, 1000, 0);
        mid_commit(7, 12345, 1);
        collect("cm_old", 0);
        run("cm_new", 0, 1000);
        wr_coef(7, 999, 1);
        run("cm_addr7", 0, 1000);
        for (int k = 0; k <= N; k++) wr_coef(k, 2048, 0);
        accept(0, 1000, 1);
        collect("cm_with_accept", 0);

        // Backpressure: x_valid held high.
        x_valid = 1'b1; x_chan = '0; x = 12'sd5;
        yv = 0;
        for (int i = 0; i < 40; i++) begin
            if (x_ready) acc_cyc.push_back(i);
            if (y_valid) yv++;
            tick();
        end
        x_valid = 1'b0;
        chk("bp_accepts", acc_cyc.size(), 5);
        for (int i = 1; i < acc_cyc.size(); i++)
            chk("bp_gap", acc_cyc[i] - acc_cyc[i-1], N + 4);
        chk("bp_outputs", yv, 5);

        // Reset in the middle of a computation.
        do_reset();
        load_taps(4096, 4096, 4096, 4096, 4096);
        run("pre_rst", 2, 700);
        accept(1, 1000, 0);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        hits = 0;
        repeat (N + 4) begin
            if (y_valid) hits++;
            tick();
        end
        chk("rst_mid_no_y", hits, 0);
        chk("rst_mid_y", y, 0);
        chk("rst_mid_chan", y_chan, 0);
        chk("rst_mid_sat", y_sat, 0);
        load_taps(4096, 4096, 4096, 4096, 4096);
        run("imp2", 0, 1000);
        for (int i = 0; i < 5; i++) run("imp2", 0, 0);

        // Random traffic with random coefficient updates.
        for (int i = 0; i < 80; i++) begin
            int r  = int'($urandom_range(0, 9));
            int ch = int'($urandom_range(0, 3));
            int xv = int'($urandom_range(0, 4095)) - 2048;
            int av = int'($urandom_range(0, 7));
            int hv = int'($urandom_range(0, 65535)) - 32768;
            if (r < 2) begin
                wr_coef(av, hv, bit'($urandom_range(0, 1)));
            end else if (r == 2 && ch < CHANNELS) begin
                accept(ch, xv, 0);
                mid_commit(av, hv, bit'($urandom_range(0, 1)));
                collect("rnd_busy", ch);
            end else begin
                run("rnd", ch, xv);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
